// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: round-robin among NREQ write requesters,
// plus a zero-fill sequence that writes 0 to x1..x31 one register per cycle.
// All register-file outputs are registered (one cycle after the handshake).
module regfile_wr_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     write,
  output logic [ADDR_W-1:0]        wrAddrD,
  output logic [DATA_W-1:0]        wrDataD,
  output logic [1:0]               grant_id
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [1:0] CLEAR_ID = 2'd3;

  state_t            state;
  state_t            stateNext;
  logic [1:0]        lastGrant;
  logic [ADDR_W-1:0] clrCnt;      // next address the zero-fill will emit
  logic              grantValid;
  logic [1:0]        grantIdx;
  logic [1:0]        cand;

  logic [ADDR_W-1:0] reqAddr [NREQ];
  logic [DATA_W-1:0] reqData [NREQ];

  // Unpack the flat request buses into per-requester fields.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign reqAddr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign reqData[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Requester index k positions after lastGrant, wrapping modulo NREQ.
  function automatic logic [1:0] rrIndex(input logic [1:0] lg, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, lg} + {1'b0, k} + 3'd1;
    if (s >= 3'(NREQ)) s = s - 3'(NREQ);
    return s[1:0];
  endfunction

  // Round-robin pick; nothing is granted under reset, while clearing,
  // or in the cycle a clear is requested (clear wins over requests).
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = 2'd0;
    cand       = 2'd0;
    req_ready  = '0;
    if (!reset && state == ARB && !clr_start) begin
      // Walk from lowest priority to highest so the closest match wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
        cand = rrIndex(lastGrant, 2'(k));
        if (req_valid[cand]) begin
          grantValid = 1'b1;
          grantIdx   = cand;
        end
      end
    end
    if (grantValid) req_ready[grantIdx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= stateNext;
  end

  // Next state: enter CLEAR on a clear request, leave once address 31 is out
  // (the counter has wrapped to zero at that point).
  always_comb begin
    stateNext = state;
    case (state)
      ARB:     if (clr_start) stateNext = CLEAR;
      CLEAR:   if (clrCnt == '0) stateNext = ARB;
      default: stateNext = ARB;
    endcase
  end

  assign clr_busy = (state == CLEAR);

  // Registered write port, round-robin pointer and zero-fill counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      write     <= 1'b0;
      wrAddrD   <= '0;
      wrDataD   <= '0;
      grant_id  <= 2'd0;
      lastGrant <= 2'd2;
      clrCnt    <= ADDR_W'(1);
    end else begin
      write <= 1'b0;
      case (state)
        ARB: begin
          if (clr_start) begin
            // First zero-fill write is issued on entry so the 31 writes
            // line up exactly with the cycles clr_busy is high.
            write    <= 1'b1;
            wrAddrD  <= clrCnt;
            wrDataD  <= '0;
            grant_id <= CLEAR_ID;
            clrCnt   <= clrCnt + 1'b1;
          end else if (grantValid) begin
            lastGrant <= grantIdx;
            grant_id  <= grantIdx;
            // x0 is hardwired zero: complete the handshake, suppress the write.
            if (reqAddr[grantIdx] != '0) begin
              write   <= 1'b1;
              wrAddrD <= reqAddr[grantIdx];
              wrDataD <= reqData[grantIdx];
            end
          end
        end
        CLEAR: begin
          if (clrCnt == '0) begin
            clrCnt <= ADDR_W'(1);
          end else begin
            write    <= 1'b1;
            wrAddrD  <= clrCnt;
            wrDataD  <= '0;
            grant_id <= CLEAR_ID;
            clrCnt   <= clrCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        clr_start;
  logic        clr_busy;
  logic        write;
  logic [4:0]  wrAddrD;
  logic [31:0] wrDataD;
  logic [1:0]  grant_id;

  regfile_wr_arbiter #(.NREQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start),
    .clr_busy(clr_busy), .write(write), .wrAddrD(wrAddrD), .wrDataD(wrDataD),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  // Model state: expected outputs for the upcoming cycle.
  bit          mInit  = 0;
  bit          mBusy  = 0;
  int          mClr   = 0;   // address currently being emitted by the zero-fill
  int          mLastG = 2;
  bit          mWrite = 0;
  logic [4:0]  mAddr  = '0;
  logic [31:0] mData  = '0;
  logic [1:0]  mGid   = '0;
  bit          mKnown = 0;   // addr/data/grant_id are defined by the rules
  int          lastPick = -1;

  // Observed values from the most recent step.
  logic [2:0]  oReady;
  logic        oBusy, oWrite;
  logic [4:0]  oAddr;
  logic [31:0] oData;
  logic [1:0]  oGid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rrPick(input int lg, input logic [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (lg + k) % 3;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input bit rst, input logic [2:0] v, input bit clr,
                      input logic [14:0] a, input logic [95:0] d);
    int g;
    logic [2:0] expReady;
    @(posedge clk); #1;
    reset = rst; req_valid = v; clr_start = clr; req_addr = a; req_data = d;
    @(negedge clk);
    g = (rst || mBusy || clr) ? -1 : rrPick(mLastG, v);
    expReady = (g < 0) ? 3'b000 : 3'(3'b001 << g);
    lastPick = g;
    oReady = req_ready; oBusy = clr_busy; oWrite = write;
    oAddr = wrAddrD; oData = wrDataD; oGid = grant_id;
    chk("ready", 32'(oReady), 32'(expReady));
    if (mInit) begin
      chk("clr_busy", 32'(oBusy), 32'(mBusy));
      chk("write", 32'(oWrite), 32'(mWrite));
      if (mKnown) begin
        chk("wrAddrD", 32'(oAddr), 32'(mAddr));
        chk("wrDataD", oData, mData);
        chk("grant_id", 32'(oGid), 32'(mGid));
      end
    end
    $display("cyc rst=%0b v=%b clr=%0b ready=%b busy=%0b write=%0b addr=%0d data=%h gid=%0d",
             rst, v, clr, oReady, oBusy, oWrite, oAddr, oData, oGid);
    if (rst) begin
      mInit = 1; mBusy = 0; mLastG = 2; mWrite = 0;
      mAddr = '0; mData = '0; mGid = '0; mKnown = 1;
    end else if (mBusy) begin
      if (mClr == 31) begin
        mBusy = 0; mWrite = 0;
      end else begin
        mClr++; mWrite = 1; mAddr = 5'(mClr); mData = '0; mGid = 2'd3;
      end
    end else if (clr) begin
      mBusy = 1; mClr = 1; mWrite = 1; mAddr = 5'd1; mData = '0; mGid = 2'd3; mKnown = 1;
    end else if (g >= 0) begin
      mLastG = g;
      if (a[g*5 +: 5] != 5'd0) begin
        mWrite = 1; mAddr = a[g*5 +: 5]; mData = d[g*32 +: 32]; mGid = 2'(g); mKnown = 1;
      end else begin
        mWrite = 0; mKnown = 0;
      end
    end else begin
      mWrite = 0;
    end
  endtask

  logic [14:0] A3;
  logic [95:0] D3;

  initial begin
    logic [2:0]  curV;
    logic [14:0] curA;
    logic [95:0] curD;
    reset = 1'b1; req_valid = '0; clr_start = 1'b0; req_addr = '0; req_data = '0;
    A3 = {5'd3, 5'd2, 5'd1};
    D3 = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    // Reset state.
    step(1, 3'b111, 0, A3, D3);
    step(1, 3'b000, 0, A3, D3);
    chk("reset_write", 32'(oWrite), 32'd0);

    // Full contention: 001, 010, 100.
    step(0, 3'b111, 0, A3, D3); chk("rr0", 32'(oReady), 32'b001);
    step(0, 3'b111, 0, A3, D3); chk("rr1", 32'(oReady), 32'b010);
    step(0, 3'b111, 0, A3, D3); chk("rr2", 32'(oReady), 32'b100);
    step(0, 3'b000, 0, A3, D3); chk("rr2_wr_gid", 32'(oGid), 32'd2);

    // Single requester 1.
    step(0, 3'b010, 0, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0});
    chk("single_ready", 32'(oReady), 32'b010);
    step(0, 3'b000, 0, A3, D3);
    chk("single_write", 32'(oWrite), 32'd1);
    chk("single_addr", 32'(oAddr), 32'd5);
    chk("single_data", oData, 32'hDEADBEEF);

    // Address-zero handshake from requester 2.
    step(0, 3'b100, 0, {5'd0, 5'd7, 5'd7}, D3);
    chk("x0_ready", 32'(oReady), 32'b100);
    step(0, 3'b111, 0, A3, D3);
    chk("x0_nowrite", 32'(oWrite), 32'd0);
    chk("x0_next_rr", 32'(oReady), 32'b001);

    // Zero-fill with pending requests and a second clr_start mid-sequence.
    step(1, 3'b000, 0, A3, D3);
    step(0, 3'b011, 1, A3, D3); chk("clr_ready", 32'(oReady), 32'b000);
    for (int i = 1; i <= 31; i++) begin
      step(0, 3'b011, (i == 12), A3, D3);
      chk("clr_addr", 32'(oAddr), 32'(i));
      chk("clr_busy_on", 32'(oBusy), 32'd1);
    end
    step(0, 3'b011, 0, A3, D3);
    chk("clr_done_busy", 32'(oBusy), 32'd0);
    chk("clr_done_ready", 32'(oReady), 32'b001);
    step(0, 3'b000, 0, A3, D3);

    // Reset in the 10th zero-fill cycle.
    step(0, 3'b000, 1, A3, D3);
    for (int i = 1; i <= 9; i++) step(0, 3'b000, 0, A3, D3);
    step(1, 3'b000, 0, A3, D3); chk("abort_addr10", 32'(oAddr), 32'd10);
    step(0, 3'b111, 0, A3, D3);
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_write", 32'(oWrite), 32'd0);
    chk("abort_ready", 32'(oReady), 32'b001);

    // Random traffic; ungranted requests keep valid and payload stable.
    curV = '0; curA = '0; curD = '0;
    for (int n = 0; n < 400; n++) begin
      bit r, c;
      for (int i = 0; i < 3; i++) begin
        if (!(curV[i] && lastPick != i && !reset)) begin
          curV[i] = ($urandom_range(0, 1) == 1);
          curA[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          curD[i*32 +: 32] = $urandom;
        end else if (lastPick == i) begin
          curV[i] = 1'b0;
        end
      end
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(r, curV, c, curA, curD);
      if (lastPick >= 0) curV[lastPick] = 1'b0;
      lastPick = -1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write requesters (fixed at 3 in this revision).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have parameter ADDR_W, default 5, register address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  3  per-requester write request; bit i = requester i.
REQ-007 SHALL have port req_ready  output  3  per-requester grant; handshake completes at posedge where valid[i] & ready[i].
REQ-008 SHALL have port req_addr  input  15  packed addresses; requester i at [5i+4:5i].
REQ-009 SHALL have port req_data  input  96  packed data; requester i at [32i+31:32i].
REQ-010 SHALL have port clr_start  input  1  one-cycle pulse requesting a zero-fill of x1..x31.
REQ-011 SHALL have port clr_busy  output  1  high while the zero-fill sequence runs.
REQ-012 SHALL have port write  output  1  register-file write enable, registered.
REQ-013 SHALL have port wrAddrD  output  5  register-file write address, registered.
REQ-014 SHALL have port wrDataD  output  32  register-file write data, registered.
REQ-015 SHALL have port grant_id  output  2  source of current write: 0..2 = requester, 3 = zero-fill.

Function
REQ-016 SHALL implement a two-state FSM: ARB and CLEAR.
REQ-017 In ARB, req_ready SHALL be combinational, one-hot or zero, granting exactly one valid requester per cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 3; last_grant updates only on a completed handshake.
REQ-019 A handshake at posedge N SHALL drive write=1, wrAddrD/wrDataD = granted request, grant_id = index, for cycle N..N+1 (one-cycle latency); regfile commits at the negedge inside that cycle.
REQ-020 Cycles without handshake SHALL drive write=0; wrAddrD/wrDataD hold previous values.
REQ-021 A handshake with address 0 SHALL complete normally (ready asserted, pointer advances) but SHALL produce write=0.
REQ-022 Requesters SHALL hold addr/data stable while valid & !ready; arbiter need not tolerate violations.
REQ-023 clr_start in ARB SHALL force req_ready=0 that cycle and enter CLEAR at next posedge.
REQ-024 clr_start together with valid requests in ARB: clear wins; no handshake that cycle.
REQ-025 In CLEAR, req_ready SHALL be 0, clr_busy SHALL be 1, and a 5-bit counter SHALL emit write=1, wrAddrD=1..31 in order, wrDataD=0, grant_id=3, one address per cycle (31 cycles).
REQ-026 After the cycle emitting address 31, FSM SHALL return to ARB; clr_busy falls with it; first grant possible that same ARB cycle.
REQ-027 clr_start while in CLEAR SHALL be ignored (no restart, no extension).
REQ-028 At most one write per cycle SHALL ever be issued.

Reset
REQ-029 On reset at posedge: state=ARB, last_grant=2 (requester 0 highest priority next), counter=1, write=0, wrAddrD=0, wrDataD=0, grant_id=0, clr_busy=0.
REQ-030 req_ready SHALL be 0 during any cycle where reset is high.
REQ-031 Reset during CLEAR SHALL abort the sequence immediately; no further zero-fill writes issued.

Verification
REQ-032 After reset, valid=3'b111 held 3 cycles -> ready sequence 001,010,100; writes from req 0,1,2 in that order, each one cycle after handshake.
REQ-033 Only req 1 valid, addr=5, data=0xDEADBEEF -> ready=010 same cycle; next cycle write=1, wrAddrD=5, wrDataD=0xDEADBEEF, grant_id=1.
REQ-034 Req 2 valid with addr=0 -> ready=100, next cycle write=0; following contention 111 grants req 0 first.
REQ-035 clr_start pulse with valid=3'b011 -> ready=000; 31 cycles write=1, addr 1..31, data 0, clr_busy=1; then req 0 granted; second clr_start mid-sequence has no effect.
REQ-036 reset asserted at 10th CLEAR cycle -> next cycle write=0, clr_busy=0, state ARB, req 0 granted first when valid.
